// File: rtl/cnt_down_timer_pkg.sv
// Shared types for the down-counting timer and the display/alarm controller
// that decodes its status outputs.
package cnt_down_timer_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned OP_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Counter-core operation selected by the control FSM each cycle.
  typedef enum logic [OP_W-1:0] {
    OP_HOLD   = 3'd0,
    OP_CLR    = 3'd1,
    OP_LOAD   = 3'd2,
    OP_RELOAD = 3'd3,
    OP_DEC    = 3'd4
  } cnt_op_e;

endpackage

// File: rtl/cnt_down_timer_if.sv
// Command/status bundle between the timer and its controlling logic.
interface cnt_down_timer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             tick;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             clear;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             paused;
  logic             done;
  logic             expired;

  modport master (
    output tick, load, load_val, start, pause, clear,
    input  q, busy, paused, done, expired
  );

  modport slave (
    input  tick, load, load_val, start, pause, clear,
    output q, busy, paused, done, expired
  );
endinterface

// File: rtl/cnt_down_timer_down_cnt_core.sv
// Period register and remaining-count register with decrement and the
// zero/one compares the control FSM needs.
module down_cnt_core
  import cnt_down_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  cnt_op_e          op,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             q_zero_c,
  output logic             q_one_c,
  output logic             period_zero_c
);

  logic [WIDTH-1:0] period;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      period <= '0;
      q      <= '0;
    end else begin
      case (op)
        OP_CLR:    q <= '0;
        OP_LOAD: begin
          period <= load_val;
          q      <= load_val;
        end
        OP_RELOAD: q <= period;
        // Saturate at zero so the count can never wrap.
        OP_DEC:    if (q != '0) q <= q - WIDTH'(1);
        default:   ;
      endcase
    end
  end

  assign q_zero_c      = (q == '0);
  assign q_one_c       = (q == WIDTH'(1));
  assign period_zero_c = (period == '0);

endmodule

// File: rtl/cnt_down_timer.sv
// Loadable down-counting timer: command priority and run/pause/done control
// around a down_cnt_core.
module cnt_down_timer
  import cnt_down_timer_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic           clk,
  input  logic           rstn,
  cnt_down_timer_if.slave tif
);

  state_e     state_q, state_d;
  cnt_op_e    op;
  logic       done_q, done_d;
  logic       expired_q, expired_d;
  logic       busy_q, paused_q;
  logic       q_zero_c, q_one_c, period_zero_c;
  logic       clr_ok_c, load_ok_c, pause_ok_c, start_ok_c;
  logic [WIDTH-1:0] q;

  down_cnt_core #(.WIDTH(WIDTH)) u_core (
    .clk           (clk),
    .rstn          (rstn),
    .op            (op),
    .load_val      (tif.load_val),
    .q             (q),
    .q_zero_c      (q_zero_c),
    .q_one_c       (q_one_c),
    .period_zero_c (period_zero_c)
  );

  // A command is only considered if it is legal in the current state.
  assign clr_ok_c   = tif.clear;
  assign load_ok_c  = tif.load && (state_q != ST_RUN);
  assign pause_ok_c = tif.pause && (state_q == ST_RUN);
  assign start_ok_c = tif.start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                    ((state_q == ST_PAUSE) && !q_zero_c));

  always_comb begin
    state_d   = state_q;
    op        = OP_HOLD;
    done_d    = 1'b0;
    expired_d = expired_q;
    if (clr_ok_c) begin
      state_d   = ST_IDLE;
      op        = OP_CLR;
      expired_d = 1'b0;
    end else if (load_ok_c) begin
      op        = OP_LOAD;
      expired_d = 1'b0;
      if (state_q == ST_DONE) state_d = ST_IDLE;
    end else if (pause_ok_c) begin
      state_d = ST_PAUSE;
    end else if (start_ok_c) begin
      expired_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (q_zero_c) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            expired_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          op = OP_RELOAD;
          if (period_zero_c) begin
            done_d    = 1'b1;
            expired_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end else if ((state_q == ST_RUN) && tif.tick && !q_zero_c) begin
      op = OP_DEC;
      if (q_one_c) begin
        done_d    = 1'b1;
        expired_d = 1'b1;
        // Auto-reload skips the zero count unless the period itself is zero.
        if (AUTO_RELOAD && !period_zero_c) op = OP_RELOAD;
        else                               state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      paused_q  <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d == ST_RUN);
      paused_q  <= (state_d == ST_PAUSE);
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign tif.q       = q;
  assign tif.busy    = busy_q;
  assign tif.paused  = paused_q;
  assign tif.done    = done_q;
  assign tif.expired = expired_q;

endmodule

// File: tb/tb_cnt_down_timer.sv
// Drives a one-shot and an auto-reload timer with identical stimulus and
// checks both against a behavioural model of the timer rules.
module tb_cnt_down_timer;

  logic clk;
  logic rstn;

  cnt_down_timer_if #(.WIDTH(16)) if0 ();
  cnt_down_timer_if #(.WIDTH(16)) if1 ();

  cnt_down_timer #(.WIDTH(16), .AUTO_RELOAD(1'b0)) dut0 (.clk(clk), .rstn(rstn), .tif(if0));
  cnt_down_timer #(.WIDTH(16), .AUTO_RELOAD(1'b1)) dut1 (.clk(clk), .rstn(rstn), .tif(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Model state per instance: index 0 one-shot, index 1 auto-reload.
  string ms [2];
  int    mq [2];
  int    mp [2];
  bit    md [2];
  bit    me [2];
  int    dcnt [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      ms[a] = "IDLE"; mq[a] = 0; mp[a] = 0; md[a] = 1'b0; me[a] = 1'b0;
    end
  endtask

  task automatic model_step(input int a, input bit tk, input bit ld, input int lv,
                            input bit st, input bit ps, input bit cl);
    md[a] = 1'b0;
    if (cl) begin
      ms[a] = "IDLE"; mq[a] = 0; me[a] = 1'b0;
    end else if (ld && ms[a] != "RUN") begin
      mp[a] = lv; mq[a] = lv; me[a] = 1'b0;
      if (ms[a] == "DONE") ms[a] = "IDLE";
    end else if (ps && ms[a] == "RUN") begin
      ms[a] = "PAUSE";
    end else if (st && ms[a] == "IDLE") begin
      if (mq[a] == 0) begin ms[a] = "DONE"; md[a] = 1'b1; me[a] = 1'b1; end
      else begin ms[a] = "RUN"; me[a] = 1'b0; end
    end else if (st && ms[a] == "PAUSE" && mq[a] != 0) begin
      ms[a] = "RUN"; me[a] = 1'b0;
    end else if (st && ms[a] == "DONE") begin
      mq[a] = mp[a];
      if (mp[a] == 0) begin md[a] = 1'b1; me[a] = 1'b1; end
      else begin ms[a] = "RUN"; me[a] = 1'b0; end
    end else if (tk && ms[a] == "RUN" && mq[a] > 0) begin
      mq[a] = mq[a] - 1;
      if (mq[a] == 0) begin
        md[a] = 1'b1; me[a] = 1'b1;
        if (a == 1 && mp[a] != 0) mq[a] = mp[a];
        else                      ms[a] = "DONE";
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " q0"},       32'(if0.q),       32'(mq[0]));
    check({tag, " busy0"},    32'(if0.busy),    32'(ms[0] == "RUN"));
    check({tag, " paused0"},  32'(if0.paused),  32'(ms[0] == "PAUSE"));
    check({tag, " done0"},    32'(if0.done),    32'(md[0]));
    check({tag, " expired0"}, 32'(if0.expired), 32'(me[0]));
    check({tag, " q1"},       32'(if1.q),       32'(mq[1]));
    check({tag, " busy1"},    32'(if1.busy),    32'(ms[1] == "RUN"));
    check({tag, " paused1"},  32'(if1.paused),  32'(ms[1] == "PAUSE"));
    check({tag, " done1"},    32'(if1.done),    32'(md[1]));
    check({tag, " expired1"}, 32'(if1.expired), 32'(me[1]));
  endtask

  task automatic drive(input bit tk, input bit ld, input int lv,
                       input bit st, input bit ps, input bit cl);
    if0.tick = tk; if0.load = ld; if0.load_val = 16'(lv);
    if0.start = st; if0.pause = ps; if0.clear = cl;
    if1.tick = tk; if1.load = ld; if1.load_val = 16'(lv);
    if1.start = st; if1.pause = ps; if1.clear = cl;
  endtask

  // One clock: apply inputs, advance model at the edge, check #1 later.
  task automatic step(input string tag, input bit tk, input bit ld, input int lv,
                      input bit st, input bit ps, input bit cl);
    drive(tk, ld, lv, st, ps, cl);
    @(posedge clk);
    model_step(0, tk, ld, lv, st, ps, cl);
    model_step(1, tk, ld, lv, st, ps, cl);
    #1;
    check_all(tag);
    if (if0.done) dcnt[0]++;
    if (if1.done) dcnt[1]++;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    model_reset();
    dcnt[0] = 0; dcnt[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #3 rstn = 1'b1;

    // Load then run to expiry.
    step("ld3", 0, 1, 3, 0, 0, 0);
    step("st", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("tick", 1, 0, 0, 0, 0, 0);
    check("run3 q0 const", 32'(if0.q), 32'd0);
    check("run3 expired0 const", 32'(if0.expired), 32'd1);
    check("run3 busy0 const", 32'(if0.busy), 32'd0);
    step("idle", 0, 0, 0, 0, 0, 0);

    // Pause and resume.
    step("clr", 0, 0, 0, 0, 0, 1);
    step("ld5", 0, 1, 5, 0, 0, 0);
    step("st", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) step("tick", 1, 0, 0, 0, 0, 0);
    step("pause", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("ptick", 1, 0, 0, 0, 0, 0);
    check("paused q0 const", 32'(if0.q), 32'd3);
    step("resume", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("tick", 1, 0, 0, 0, 0, 0);

    // Priority and collisions.
    step("clr", 0, 0, 0, 0, 0, 1);
    step("ld4", 0, 1, 4, 0, 0, 0);
    step("st", 0, 0, 0, 1, 0, 0);
    step("tick", 1, 0, 0, 0, 0, 0);
    step("tick", 1, 0, 0, 0, 0, 0);
    step("clr+ld+tick", 1, 1, 9, 0, 0, 1);
    check("clr prio q0 const", 32'(if0.q), 32'd0);
    step("ld6", 0, 1, 6, 0, 0, 0);
    step("st", 0, 0, 0, 1, 0, 0);
    step("pause+tick", 1, 0, 0, 1, 1, 0);
    step("resume", 0, 0, 0, 1, 0, 0);
    step("ld in run", 0, 1, 1, 0, 0, 0);
    step("ld+tick in run", 1, 1, 1, 0, 0, 0);

    // Zero count.
    step("clr", 0, 0, 0, 0, 0, 1);
    step("ld0", 0, 1, 0, 0, 0, 0);
    step("st0", 0, 0, 0, 1, 0, 0);
    check("zero done0 const", 32'(if0.done), 32'd1);
    step("idle", 0, 0, 0, 0, 0, 0);
    step("st0 again", 0, 0, 0, 1, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0);

    // Auto-reload period 2, six ticks.
    step("clr", 0, 0, 0, 0, 0, 1);
    step("ld2", 0, 1, 2, 0, 0, 0);
    step("st", 0, 0, 0, 1, 0, 0);
    dcnt[0] = 0; dcnt[1] = 0;
    for (int i = 0; i < 6; i++) step("atick", 1, 0, 0, 0, 0, 0);
    check("auto done count1", 32'(dcnt[1]), 32'd3);
    check("oneshot done count0", 32'(dcnt[0]), 32'd1);

    // Asynchronous reset mid-run at q=7.
    step("clr", 0, 0, 0, 0, 0, 1);
    step("ld10", 0, 1, 10, 0, 0, 0);
    step("st", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("tick", 1, 0, 0, 0, 0, 0);
    check("pre-reset q0 const", 32'(if0.q), 32'd7);
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("async rst");
    #1 rstn = 1'b1;
    for (int i = 0; i < 3; i++) step("post-rst tick", 1, 0, 0, 0, 0, 0);
    step("ld4", 0, 1, 4, 0, 0, 0);
    step("st", 0, 0, 0, 1, 0, 0);
    step("tick", 1, 0, 0, 0, 0, 0);

    // Randomized command mix.
    for (int i = 0; i < 300; i++) begin
      bit tk, ld, st, ps, cl;
      int lv;
      tk = ($urandom_range(99, 0) < 55);
      ld = ($urandom_range(99, 0) < 10);
      st = ($urandom_range(99, 0) < 15);
      ps = ($urandom_range(99, 0) < 8);
      cl = ($urandom_range(99, 0) < 4);
      lv = int'($urandom_range(6, 0));
      step("rand", tk, ld, lv, st, ps, cl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
